vga_fb_arbiter: RTL and testbench
=================================

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameter FB_W, default 160: framebuffer width in stored pixels.
REQ-002 Parameter FB_H, default 120: framebuffer height in stored pixels.
REQ-003 Parameter SCALE_SH, default 2: screen-to-framebuffer shift; each stored pixel covers 4x4 screen pixels.
REQ-004 Parameter DW, default 12: pixel width (4R4G4B).
REQ-005 Parameter AW, default 15: framebuffer address width.
REQ-006 clk_100MHz  in  1  single system clock; all logic on rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 p_tick  in  1  one-cycle pixel strobe, nominally 1 of every 4 clocks.
REQ-009 video_on  in  1  current x/y in the visible 640x480 area.
REQ-010 x, y  in  10 each  current scan position; stable while p_tick is high.
REQ-011 wr_valid / wr_ready  in / out  1 each  writer handshake; transfer when both are high.
REQ-012 wr_addr, wr_data  in  AW, DW  writer address and pixel.
REQ-013 mem_en, mem_we  out  1 each  RAM port enable and write enable.
REQ-014 mem_addr, mem_wdata  out  AW, DW  RAM port address and write data.
REQ-015 mem_rdata  in  DW  RAM read data, valid the cycle after a read.
REQ-016 rgb  out  DW  registered pixel to the DAC.
REQ-017 wr_err  out  1  one-cycle pulse when an out-of-range write is discarded.
REQ-018 fifo_level  out  3  write FIFO occupancy, 0..4.

Function
REQ-019 The single-port RAM shall be shared between display scan-out (priority) and a 4-entry write FIFO.
REQ-020 Display address shall be (y>>SCALE_SH)*FB_W + (x>>SCALE_SH), computed to AW bits with no truncation for in-range x/y.
REQ-021 The FSM shall have two states, FREE and CAPTURE, and shall enter FREE on reset.
REQ-022 In FREE, if p_tick and video_on are both high: drive mem_en=1, mem_we=0, mem_addr=display address, and go to CAPTURE.
REQ-023 In FREE, with no display read and the FIFO non-empty: pop the head entry and drive mem_en=1, mem_we=1, mem_addr/mem_wdata from that entry.
REQ-024 In CAPTURE: register rgb<=mem_rdata, issue no write, and return to FREE.
REQ-025 If p_tick and video_on are high in CAPTURE: capture rgb and issue the new display read in the same cycle, staying in CAPTURE.
REQ-026 If p_tick is high and video_on is low: register rgb<=0 on that edge, issue no read, and a write is permitted that cycle.
REQ-027 Display latency shall be 2 clocks from the p_tick cycle to rgb updating (read, then capture).
REQ-028 Outside read and capture cycles, mem_en and mem_we shall be 0.
REQ-029 wr_ready shall equal (fifo_level<4), registered-free, with no bypass from pop to ready.
REQ-030 When full, wr_ready shall be 0 and no push shall occur; wr_valid held high shall be accepted once space frees.
REQ-031 Push and pop in the same cycle shall leave fifo_level unchanged; FIFO order shall be strict FIFO.
REQ-032 A popped entry with wr_addr >= FB_W*FB_H shall not drive mem_en and shall pulse wr_err for 1 cycle in the pop cycle.
REQ-033 In active video, at least 2 of every 4 clocks shall be available for writes.
REQ-034 Writes shall never be starved by blanking, and shall never delay a display read.

Reset
REQ-035 While reset_n=0: state=FREE, FIFO empty, fifo_level=0, rgb=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, wr_err=0, wr_ready=0.
REQ-036 wr_ready shall rise on the first clock edge after reset_n deasserts.
REQ-037 Reset asserted mid-operation shall discard pending FIFO entries and any in-flight capture, with no RAM access after assertion.

Verification
REQ-038 p_tick at x=8, y=4, video_on=1 -> same cycle mem_addr=162 with mem_we=0; mem_rdata=0xABC the next cycle -> rgb=0xABC one cycle later.
REQ-039 Push 4 writes while the display idles -> fifo_level reaches 4 and wr_ready=0; drains in order at 1 per FREE cycle to fifo_level=0.
REQ-040 wr_valid in the same cycle as p_tick&&video_on with a non-empty FIFO -> display read wins and the write issues the next FREE cycle, with no data loss.
REQ-041 wr_addr=19200 -> wr_err pulses once, mem_en stays 0, and fifo_level decrements.
REQ-042 p_tick with video_on=0 -> rgb=0 next edge, and a queued write issues in that same cycle.
REQ-043 reset_n low with 3 entries queued and a capture pending -> all outputs go to their REQ-035 values immediately, and after release fifo_level=0 and wr_ready=1.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - single-port framebuffer RAM arbiter: display scan-out over a 4-entry write FIFO
module vga_fb_arbiter #(
  parameter int FB_W     = 160,
  parameter int FB_H     = 120,
  parameter int SCALE_SH = 2,
  parameter int DW       = 12,
  parameter int AW       = 15
) (
  input  logic          clk_100MHz,
  input  logic          reset_n,
  input  logic          p_tick,
  input  logic          video_on,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] rgb,
  output logic          wr_err,
  output logic [2:0]    fifo_level
);

  localparam int unsigned FB_SIZE = FB_W * FB_H;

  typedef enum logic {FREE = 1'b0, CAPTURE = 1'b1} state_e;

  state_e          state_q;
  logic [DW-1:0]   rgb_q;

  logic [AW-1:0]   addr_mem_q [4];
  logic [DW-1:0]   data_mem_q [4];
  logic [1:0]      wptr_q, rptr_q;
  logic [2:0]      level_q, level_d;
  logic            ready_en_q;

  logic            disp_rd;
  logic            wr_push;
  logic            wr_pop;
  logic            head_bad;
  logic [AW-1:0]   head_addr;
  logic [DW-1:0]   head_data;
  logic [AW-1:0]   disp_addr;

  // Display read has absolute priority; masking with reset_n keeps the RAM quiet during reset
  assign disp_rd   = reset_n && p_tick && video_on;
  assign disp_addr = AW'(y >> SCALE_SH) * AW'(FB_W) + AW'(x >> SCALE_SH);

  assign head_addr = addr_mem_q[rptr_q];
  assign head_data = data_mem_q[rptr_q];
  assign head_bad  = 32'(head_addr) >= FB_SIZE;

  // Writes only use cycles the display leaves free: FREE state and no read being issued
  assign wr_pop    = reset_n && (state_q == FREE) && !disp_rd && (level_q != 3'd0);
  // Ready depends only on registered level, so a pop never bypasses into ready
  assign wr_ready  = ready_en_q && (level_q != 3'd4);
  assign wr_push   = wr_valid && wr_ready;

  assign rgb        = rgb_q;
  assign fifo_level = level_q;
  assign wr_err     = wr_pop && head_bad;

  // RAM port drive: display read, else a popped in-range write, else idle at zero
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (disp_rd) begin
      mem_en   = 1'b1;
      mem_addr = disp_addr;
    end else if (wr_pop && !head_bad) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = head_addr;
      mem_wdata = head_data;
    end
  end

  // FREE/CAPTURE scan-out FSM and the registered DAC pixel
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FREE;
      rgb_q   <= '0;
    end else begin
      case (state_q)
        FREE: begin
          if (disp_rd) begin
            state_q <= CAPTURE;
          end else if (p_tick) begin
            rgb_q <= '0;
          end
        end
        CAPTURE: begin
          rgb_q   <= mem_rdata;
          state_q <= disp_rd ? CAPTURE : FREE;
        end
        default: state_q <= FREE;
      endcase
    end
  end

  // Occupancy next-state: simultaneous push and pop cancel out
  always_comb begin
    level_d = level_q;
    if (wr_push && !wr_pop) begin
      level_d = level_q + 3'd1;
    end else if (wr_pop && !wr_push) begin
      level_d = level_q - 3'd1;
    end
  end

  // FIFO pointers and occupancy; reset drops any queued entries
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= 2'd0;
      rptr_q  <= 2'd0;
      level_q <= 3'd0;
    end else begin
      if (wr_push) wptr_q <= wptr_q + 2'd1;
      if (wr_pop)  rptr_q <= rptr_q + 2'd1;
      level_q <= level_d;
    end
  end

  // FIFO storage needs no reset: entries are only read when counted valid
  always_ff @(posedge clk_100MHz) begin
    if (wr_push) begin
      addr_mem_q[wptr_q] <= wr_addr;
      data_mem_q[wptr_q] <= wr_data;
    end
  end

  // Holds wr_ready low in reset and releases it on the first edge afterwards
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - directed self-checking bench for vga_fb_arbiter
module tb_vga_fb_arbiter;

  logic        clk_100MHz;
  logic        reset_n;
  logic        p_tick;
  logic        video_on;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        wr_valid;
  logic        wr_ready;
  logic [14:0] wr_addr;
  logic [11:0] wr_data;
  logic        mem_en;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;
  logic [11:0] rgb;
  logic        wr_err;
  logic [2:0]  fifo_level;

  int n_checks;
  int n_fail;

  vga_fb_arbiter dut (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .p_tick     (p_tick),
    .video_on   (video_on),
    .x          (x),
    .y          (y),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .rgb        (rgb),
    .wr_err     (wr_err),
    .fifo_level (fifo_level)
  );

  initial begin
    clk_100MHz = 1'b0;
    forever #5 clk_100MHz = ~clk_100MHz;
  end

  task automatic test_reset;
    @(negedge clk_100MHz);
    p_tick = 1'b1; video_on = 1'b1; x = 10'd8; y = 10'd4; wr_valid = 1'b1; wr_addr = 15'd5; wr_data = 12'h001;
    #1;
    n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en: got %0h want 0", mem_en); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %0h want 0", mem_we); end
    n_checks++; if (mem_addr !== 15'd0) begin n_fail++; $display("FAIL reset_mem_addr: got %0d want 0", mem_addr); end
    n_checks++; if (mem_wdata !== 12'd0) begin n_fail++; $display("FAIL reset_mem_wdata: got %0h want 0", mem_wdata); end
    n_checks++; if (rgb !== 12'd0) begin n_fail++; $display("FAIL reset_rgb: got %0h want 0", rgb); end
    n_checks++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL reset_wr_err: got %0h want 0", wr_err); end
    n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready: got %0h want 0", wr_ready); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    @(negedge clk_100MHz);
    p_tick = 1'b0; video_on = 1'b0; wr_valid = 1'b0; reset_n = 1'b1;
    #1;
    n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL release_ready_early: got %0h want 0", wr_ready); end
    @(negedge clk_100MHz);
    #1;
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %0h want 1", wr_ready); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL release_level: got %0d want 0", fifo_level); end
  endtask

  task automatic test_display_read;
    @(negedge clk_100MHz);
    p_tick = 1'b1; video_on = 1'b1; x = 10'd8; y = 10'd4;
    #1;
    n_checks++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL disp_mem_en: got %0h want 1", mem_en); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL disp_mem_we: got %0h want 0", mem_we); end
    n_checks++; if (mem_addr !== 15'd162) begin n_fail++; $display("FAIL disp_addr_162: got %0d want 162", mem_addr); end
    @(negedge clk_100MHz);
    p_tick = 1'b0; mem_rdata = 12'hABC;
    #1;
    n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL capture_mem_en: got %0h want 0", mem_en); end
    n_checks++; if (rgb !== 12'd0) begin n_fail++; $display("FAIL rgb_not_yet: got %0h want 0", rgb); end
    @(negedge clk_100MHz);
    mem_rdata = 12'h000; p_tick = 1'b1; video_on = 1'b1; x = 10'd639; y = 10'd479;
    #1;
    n_checks++; if (rgb !== 12'hABC) begin n_fail++; $display("FAIL disp_rgb: got %0h want abc", rgb); end
    n_checks++; if (mem_addr !== 15'd19199) begin n_fail++; $display("FAIL disp_addr_max: got %0d want 19199", mem_addr); end
    @(negedge clk_100MHz);
    p_tick = 1'b0; mem_rdata = 12'h3C3;
    @(negedge clk_100MHz);
    #1;
    n_checks++; if (rgb !== 12'h3C3) begin n_fail++; $display("FAIL disp_rgb2: got %0h want 3c3", rgb); end
  endtask

  task automatic test_fifo_fill;
    logic [14:0] ea [5];
    logic [11:0] ed [5];
    logic [2:0]  el [5];
    logic        acc;
    ea = '{15'd100, 15'd101, 15'd102, 15'd103, 15'd500};
    ed = '{12'h0A1, 12'h0A2, 12'h0A3, 12'h0A4, 12'h555};
    el = '{3'd4, 3'd3, 3'd3, 3'd2, 3'd1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_100MHz);
      p_tick = 1'b1; video_on = 1'b1; x = 10'd0; y = 10'd0;
      wr_valid = 1'b1; wr_addr = ea[i]; wr_data = ed[i];
      #1;
      n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL fill_no_write[%0d]: got %0h want 0", i, mem_we); end
    end
    @(negedge clk_100MHz);
    wr_addr = ea[4]; wr_data = ed[4];
    #1;
    n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL fill_level: got %0d want 4", fifo_level); end
    n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got %0h want 0", wr_ready); end
    @(negedge clk_100MHz);
    #1;
    n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL full_hold_level: got %0d want 4", fifo_level); end
    @(negedge clk_100MHz);
    p_tick = 1'b0;
    #1;
    n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL drain_capture_idle: got %0h want 0", mem_en); end
    acc = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_100MHz);
      if (acc) wr_valid = 1'b0;
      #1;
      acc = wr_valid && wr_ready;
      n_checks++; if (fifo_level !== el[i]) begin n_fail++; $display("FAIL drain_level[%0d]: got %0d want %0d", i, fifo_level, el[i]); end
      n_checks++; if ({mem_en, mem_we} !== 2'b11) begin n_fail++; $display("FAIL drain_en_we[%0d]: got %b want 11", i, {mem_en, mem_we}); end
      n_checks++; if (mem_addr !== ea[i]) begin n_fail++; $display("FAIL drain_addr[%0d]: got %0d want %0d", i, mem_addr, ea[i]); end
      n_checks++; if (mem_wdata !== ed[i]) begin n_fail++; $display("FAIL drain_data[%0d]: got %0h want %0h", i, mem_wdata, ed[i]); end
    end
    @(negedge clk_100MHz);
    wr_valid = 1'b0;
    #1;
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL drain_empty: got %0d want 0", fifo_level); end
    n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL drain_idle: got %0h want 0", mem_en); end
  endtask

  task automatic test_collision;
    @(negedge clk_100MHz);
    p_tick = 1'b1; video_on = 1'b1; x = 10'd0; y = 10'd0;
    wr_valid = 1'b1; wr_addr = 15'd200; wr_data = 12'h111;
    #1;
    n_checks++; if ({mem_en, mem_we} !== 2'b10) begin n_fail++; $display("FAIL coll_rd1: got %b want 10", {mem_en, mem_we}); end
    @(negedge clk_100MHz);
    p_tick = 1'b0; wr_addr = 15'd201; wr_data = 12'h222;
    #1;
    n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL coll_capture: got %0h want 0", mem_en); end
    @(negedge clk_100MHz);
    p_tick = 1'b1; video_on = 1'b1; x = 10'd20; y = 10'd8; wr_addr = 15'd202; wr_data = 12'h333;
    #1;
    n_checks++; if (fifo_level !== 3'd2) begin n_fail++; $display("FAIL coll_level: got %0d want 2", fifo_level); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL coll_read_wins_we: got %0h want 0", mem_we); end
    n_checks++; if (mem_addr !== 15'd325) begin n_fail++; $display("FAIL coll_read_addr: got %0d want 325", mem_addr); end
    @(negedge clk_100MHz);
    p_tick = 1'b0; wr_valid = 1'b0;
    #1;
    n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL coll_capture2: got %0h want 0", mem_en); end
    n_checks++; if (fifo_level !== 3'd3) begin n_fail++; $display("FAIL coll_level3: got %0d want 3", fifo_level); end
    @(negedge clk_100MHz);
    #1;
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 15'd200 || mem_wdata !== 12'h111) begin n_fail++; $display("FAIL coll_pop_a: got we=%0h addr=%0d data=%0h want we=1 addr=200 data=111", mem_we, mem_addr, mem_wdata); end
    @(negedge clk_100MHz);
    #1;
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 15'd201 || mem_wdata !== 12'h222) begin n_fail++; $display("FAIL coll_pop_b: got we=%0h addr=%0d data=%0h want we=1 addr=201 data=222", mem_we, mem_addr, mem_wdata); end
    @(negedge clk_100MHz);
    #1;
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 15'd202 || mem_wdata !== 12'h333) begin n_fail++; $display("FAIL coll_pop_c: got we=%0h addr=%0d data=%0h want we=1 addr=202 data=333", mem_we, mem_addr, mem_wdata); end
    @(negedge clk_100MHz);
    #1;
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL coll_empty: got %0d want 0", fifo_level); end
  endtask

  task automatic test_bad_addr;
    @(negedge clk_100MHz);
    p_tick = 1'b0; wr_valid = 1'b1; wr_addr = 15'd19200; wr_data = 12'hBAD;
    #1;
    n_checks++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL bad_err_early: got %0h want 0", wr_err); end
    @(negedge clk_100MHz);
    wr_addr = 15'd19199; wr_data = 12'h0F0;
    #1;
    n_checks++; if (wr_err !== 1'b1) begin n_fail++; $display("FAIL bad_err_pulse: got %0h want 1", wr_err); end
    n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL bad_mem_en: got %0h want 0", mem_en); end
    n_checks++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL bad_level_before: got %0d want 1", fifo_level); end
    @(negedge clk_100MHz);
    wr_valid = 1'b0;
    #1;
    n_checks++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL push_pop_level: got %0d want 1", fifo_level); end
    n_checks++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL bad_err_once: got %0h want 0", wr_err); end
    n_checks++; if (mem_en !== 1'b1 || mem_addr !== 15'd19199 || mem_wdata !== 12'h0F0) begin n_fail++; $display("FAIL edge_addr_write: got en=%0h addr=%0d data=%0h want en=1 addr=19199 data=0f0", mem_en, mem_addr, mem_wdata); end
    @(negedge clk_100MHz);
    #1;
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL bad_level_after: got %0d want 0", fifo_level); end
  endtask

  task automatic test_blank;
    @(negedge clk_100MHz);
    p_tick = 1'b1; video_on = 1'b1; x = 10'd4; y = 10'd0;
    #1;
    n_checks++; if (mem_addr !== 15'd1) begin n_fail++; $display("FAIL blank_pre_addr: got %0d want 1", mem_addr); end
    @(negedge clk_100MHz);
    p_tick = 1'b0; mem_rdata = 12'h5A5; wr_valid = 1'b1; wr_addr = 15'd300; wr_data = 12'h777;
    @(negedge clk_100MHz);
    wr_valid = 1'b0; p_tick = 1'b1; video_on = 1'b0;
    #1;
    n_checks++; if (rgb !== 12'h5A5) begin n_fail++; $display("FAIL blank_pre_rgb: got %0h want 5a5", rgb); end
    n_checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 15'd300 || mem_wdata !== 12'h777) begin n_fail++; $display("FAIL blank_write: got en=%0h we=%0h addr=%0d data=%0h want 1 1 300 777", mem_en, mem_we, mem_addr, mem_wdata); end
    @(negedge clk_100MHz);
    p_tick = 1'b0;
    #1;
    n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL blank_rgb: got %0h want 0", rgb); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL blank_level: got %0d want 0", fifo_level); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk_100MHz);
    p_tick = 1'b1; video_on = 1'b1; x = 10'd40; y = 10'd40;
    wr_valid = 1'b1; wr_addr = 15'd400; wr_data = 12'h401;
    @(negedge clk_100MHz);
    mem_rdata = 12'h123; wr_addr = 15'd401; wr_data = 12'h402;
    @(negedge clk_100MHz);
    wr_addr = 15'd402; wr_data = 12'h403;
    @(negedge clk_100MHz);
    wr_valid = 1'b0;
    #1;
    n_checks++; if (fifo_level !== 3'd3) begin n_fail++; $display("FAIL mid_pre_level: got %0d want 3", fifo_level); end
    n_checks++; if (rgb !== 12'h123) begin n_fail++; $display("FAIL mid_pre_rgb: got %0h want 123", rgb); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL mid_rgb: got %0h want 0", rgb); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL mid_level: got %0d want 0", fifo_level); end
    n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got %0h want 0", wr_ready); end
    n_checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 15'd0 || mem_wdata !== 12'd0) begin n_fail++; $display("FAIL mid_mem: got en=%0h we=%0h addr=%0d data=%0h want all 0", mem_en, mem_we, mem_addr, mem_wdata); end
    @(negedge clk_100MHz);
    #1;
    n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL mid_hold_mem_en: got %0h want 0", mem_en); end
    p_tick = 1'b0; video_on = 1'b0; reset_n = 1'b1;
    @(negedge clk_100MHz);
    #1;
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL mid_release_ready: got %0h want 1", wr_ready); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL mid_release_level: got %0d want 0", fifo_level); end
    n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL mid_release_no_write: got %0h want 0", mem_en); end
    n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL mid_release_rgb: got %0h want 0", rgb); end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    p_tick    = 1'b0;
    video_on  = 1'b0;
    x         = 10'd0;
    y         = 10'd0;
    wr_valid  = 1'b0;
    wr_addr   = 15'd0;
    wr_data   = 12'd0;
    mem_rdata = 12'd0;
    test_reset;
    test_display_read;
    test_fifo_fill;
    test_collision;
    test_bad_addr;
    test_blank;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
